// File: rtl/pcie_rx_merge.sv
// pcie_rx_merge: receive-side merge of two destination streams (D0, D1).
// Each stream lands in a small FIFO. The FIFOs are drained round-robin into
// one registered output stream. Per-destination pause flags go back to the
// sender. A small control FSM (RESET/INIT/IDLE/ACTIVE/ERROR) mirrors the
// transmit side.
// Optional feature: define RX_DEST_CHECK_EN to drop words whose destination
// bit does not match the port they arrive on. Such a drop sets a sticky
// dest_err flag.

// One destination FIFO: pointer based, occupancy counter one bit wider
module pcie_rx_merge_fifo #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   occ
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    // pointers wrap naturally modulo DEPTH; occupancy tracks push/pop balance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
        end
    end

    // storage needs no reset: an empty FIFO is never read
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
endmodule

module pcie_rx_merge #(
    parameter int DATA_W  = 6,
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 2,
    parameter int UMB_DEF = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [1:0]        umbral_in,
    input  logic [DATA_W-1:0] data_in0,
    input  logic              push0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              push1,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              pausa0,
    output logic              pausa1,
    output logic [4:0]        count0,
    output logic [4:0]        count1,
    output logic              idle_out,
    output logic              active_out,
    output logic              error_out,
    output logic              dest_err
);
    localparam int DEST_BIT = 4;
    localparam logic [ADDR_W:0]   FULL_OCC  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W+1:0] DEPTH_EXT = (ADDR_W+2)'(DEPTH);

    typedef enum logic [2:0] {
        S_RESET, S_INIT, S_IDLE, S_ACTIVE, S_ERROR
    } state_t;

    state_t state, state_nx;

    logic [1:0][DATA_W-1:0] din;
    logic [1:0][DATA_W-1:0] rdata;
    logic [1:0][ADDR_W:0]   occ;
    logic [1:0]             push;
    logic [1:0]             wr_ok;      // push that survives the destination check
    logic [1:0]             full;
    logic [1:0]             nonempty;
    logic [1:0]             rd;
    logic [1:0]             wr;
    logic [1:0]             ovf;
    logic [1:0]             pausa;
    logic [1:0]             umbral;
    logic                   rr_ptr;     // 0: D0 wins a tie, 1: D1 wins
    logic                   pop_en;
    logic                   take;
    logic                   sel;
    logic                   overflow;

    assign din  = {data_in1, data_in0};
    assign push = {push1, push0};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dst
`ifdef RX_DEST_CHECK_EN
            assign wr_ok[g] = push[g] && (din[g][DEST_BIT] == 1'(g));
`else
            assign wr_ok[g] = push[g];
`endif
            assign full[g]     = (occ[g] == FULL_OCC);
            assign nonempty[g] = (occ[g] != '0);
            // a full FIFO still accepts a word when it is popped the same cycle
            assign wr[g]       = wr_ok[g] && (!full[g] || rd[g]);
            assign ovf[g]      = wr_ok[g] && full[g] && !rd[g];
            // free <= umbral  <=>  occ + umbral >= DEPTH
            assign pausa[g]    = ({1'b0, occ[g]} + {{ADDR_W{1'b0}}, umbral}) >= DEPTH_EXT;

            pcie_rx_merge_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH),
                .ADDR_W (ADDR_W)
            ) u_fifo (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (wr[g]),
                .wr_data (din[g]),
                .rd_en   (rd[g]),
                .rd_data (rdata[g]),
                .occ     (occ[g])
            );
        end
    endgenerate

    // pops are honoured only while the path is up; a tie goes to the RR pointer
    assign pop_en   = pop && (state == S_IDLE || state == S_ACTIVE);
    assign take     = pop_en && (|nonempty);
    assign sel      = (&nonempty) ? rr_ptr : nonempty[1];
    assign rd[0]    = take && !sel;
    assign rd[1]    = take && sel;
    assign overflow = |ovf;

    assign pausa0     = pausa[0];
    assign pausa1     = pausa[1];
    assign idle_out   = (state == S_IDLE);
    assign active_out = (state == S_ACTIVE);
    assign error_out  = (state == S_ERROR);

    // control state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_RESET;
        else       state <= state_nx;
    end

    // next state: overflow beats init, init beats the IDLE/ACTIVE decisions
    always_comb begin
        state_nx = state;
        case (state)
            S_RESET: state_nx = S_INIT;
            S_ERROR: state_nx = S_ERROR;
            default: begin
                if (overflow)        state_nx = S_ERROR;
                else if (init)       state_nx = S_INIT;
                else if (state == S_INIT)
                    state_nx = S_IDLE;
                else if (state == S_IDLE) begin
                    if (|nonempty) state_nx = S_ACTIVE;
                end else if (!(|nonempty) && !(|wr_ok))
                    state_nx = S_IDLE;
            end
        endcase
    end

    // merged output word, RR pointer and per-destination delivery counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            rr_ptr    <= 1'b0;
            count0    <= '0;
            count1    <= '0;
        end else begin
            valid_out <= take;
            if (take) begin
                data_out <= rdata[sel];
                rr_ptr   <= !sel;
            end
            if (rd[0] && count0 != 5'd31) count0 <= count0 + 5'd1;
            if (rd[1] && count1 != 5'd31) count1 <= count1 + 5'd1;
        end
    end

    // pause threshold, loaded continuously while init is held in INIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       umbral <= 2'(UMB_DEF);
        else if (state == S_INIT && init) umbral <= umbral_in;
    end

`ifdef RX_DEST_CHECK_EN
    // sticky flag for any word rejected by the destination check
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 dest_err <= 1'b0;
        else if (|(push & ~wr_ok)) dest_err <= 1'b1;
    end
`else
    assign dest_err = 1'b0;
`endif
endmodule

// File: tb/tb_pcie_rx_merge.sv
// Bench for pcie_rx_merge: directed scenarios plus randomized traffic.
// Both are checked every cycle against a queue-based reference model.
module tb_pcie_rx_merge;
    localparam int DEPTH = 4;
    localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_ERROR = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init = 1'b0;
    logic [1:0] umbral_in = 2'd1;
    logic [5:0] data_in0 = '0, data_in1 = '0;
    logic       push0 = 1'b0, push1 = 1'b0, pop = 1'b0;
    logic [5:0] data_out;
    logic       valid_out, pausa0, pausa1, idle_out, active_out, error_out, dest_err;
    logic [4:0] count0, count1;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         m_st;
    logic [5:0] q0[$];
    logic [5:0] q1[$];
    bit         m_ptr;
    int         m_umb, m_c0, m_c1;
    logic [5:0] m_dout;
    bit         m_vout, m_derr;

    pcie_rx_merge dut (
        .clk(clk), .reset(reset), .init(init), .umbral_in(umbral_in),
        .data_in0(data_in0), .push0(push0), .data_in1(data_in1), .push1(push1),
        .pop(pop), .data_out(data_out), .valid_out(valid_out),
        .pausa0(pausa0), .pausa1(pausa1), .count0(count0), .count1(count1),
        .idle_out(idle_out), .active_out(active_out), .error_out(error_out),
        .dest_err(dest_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_RESET;
        q0.delete();
        q1.delete();
        m_ptr = 0; m_umb = 1; m_c0 = 0; m_c1 = 0;
        m_dout = '0; m_vout = 0; m_derr = 0;
    endtask

    // one clock edge of the model, using the inputs as sampled at that edge
    task automatic model_edge();
        bit ok0, ok1, take, sel, ov;
        int n0, n1;
        logic [5:0] w;
        n0 = q0.size();
        n1 = q1.size();
        ok0 = push0;
        ok1 = push1;
`ifdef RX_DEST_CHECK_EN
        if (push0 && data_in0[4] !== 1'b0) begin ok0 = 0; m_derr = 1; end
        if (push1 && data_in1[4] !== 1'b1) begin ok1 = 0; m_derr = 1; end
`endif
        take = pop && (m_st == M_IDLE || m_st == M_ACTIVE) && (n0 + n1 > 0);
        sel  = (n0 > 0 && n1 > 0) ? m_ptr : (n1 > 0);
        m_vout = take;
        if (take) begin
            if (sel) begin
                w = q1.pop_front();
                if (m_c1 < 31) m_c1++;
            end else begin
                w = q0.pop_front();
                if (m_c0 < 31) m_c0++;
            end
            m_dout = w;
            m_ptr  = !sel;
        end
        ov = 0;
        if (ok0) begin
            if (n0 < DEPTH || (take && !sel)) q0.push_back(data_in0);
            else ov = 1;
        end
        if (ok1) begin
            if (n1 < DEPTH || (take && sel)) q1.push_back(data_in1);
            else ov = 1;
        end
        if (m_st == M_INIT && init) m_umb = umbral_in;
        if (m_st == M_RESET)       m_st = M_INIT;
        else if (m_st == M_ERROR)  m_st = M_ERROR;
        else if (ov)               m_st = M_ERROR;
        else if (init)             m_st = M_INIT;
        else if (m_st == M_INIT)   m_st = M_IDLE;
        else if (m_st == M_IDLE) begin
            if (n0 + n1 > 0) m_st = M_ACTIVE;
        end else if (n0 + n1 == 0 && !ok0 && !ok1) m_st = M_IDLE;
    endtask

    task automatic check_outs();
        chk("data_out",   data_out,   m_dout);
        chk("valid_out",  valid_out,  m_vout);
        chk("pausa0",     pausa0,     (DEPTH - q0.size()) <= m_umb);
        chk("pausa1",     pausa1,     (DEPTH - q1.size()) <= m_umb);
        chk("count0",     count0,     m_c0);
        chk("count1",     count1,     m_c1);
        chk("idle_out",   idle_out,   m_st == M_IDLE);
        chk("active_out", active_out, m_st == M_ACTIVE);
        chk("error_out",  error_out,  m_st == M_ERROR);
        chk("dest_err",   dest_err,   m_derr);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic clr_in();
        push0 = 0; push1 = 0; pop = 0; init = 0;
        data_in0 = '0; data_in1 = '0;
    endtask

    // asynchronous reset asserted mid-cycle, released on a falling edge
    task automatic do_reset();
        #2;
        reset = 1'b1;
        clr_in();
        #1;
        model_reset();
        check_outs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // RESET -> INIT (init held) -> INIT loads threshold -> IDLE
    task automatic bring_up(input logic [1:0] umb);
        init = 1; umbral_in = umb;
        step();
        step();
        init = 0;
        step();
    endtask

    task automatic drain();
        clr_in();
        pop = 1;
        for (int i = 0; i < 12; i++) step();
        pop = 0;
        step();
    endtask

    function automatic logic [5:0] rnd_word(input bit dst);
        logic [5:0] w;
        w = 6'($urandom);
`ifdef RX_DEST_CHECK_EN
        if ($urandom_range(0, 9) != 0) w[4] = dst;
`else
        if (dst) w[4] = w[4];
`endif
        return w;
    endfunction

    initial begin
        model_reset();
        #12;
        check_outs();
        @(negedge clk);
        reset = 1'b0;

        // threshold 2: pausa0 rises once two words sit in D0
        bring_up(2'd2);
        chk("t1_idle", idle_out, 1);
        push0 = 1; data_in0 = 6'h01; step();
        chk("t1_pausa0_1push", pausa0, 0);
        data_in0 = 6'h02; step();
        chk("t1_pausa0_2push", pausa0, 1);
        drain();

        // simultaneous D0/D1 words, drained in order D0 then D1
        do_reset();
        bring_up(2'd1);
        push0 = 1; data_in0 = 6'h05; push1 = 1; data_in1 = 6'h13; step();
        clr_in(); pop = 1; step();
        chk("t2_first", data_out, 6'h05);
        chk("t2_first_v", valid_out, 1);
        step();
        chk("t2_second", data_out, 6'h13);
        chk("t2_second_v", valid_out, 1);
        pop = 0; step();
        chk("t2_valid_low", valid_out, 0);
        chk("t2_count0", count0, 1);
        chk("t2_count1", count1, 1);
        chk("t2_idle", idle_out, 1);

        // overflow into a full D0 without a pop -> sticky error, pop ignored
        do_reset();
        bring_up(2'd1);
        push0 = 1;
        for (int i = 1; i <= 4; i++) begin data_in0 = 6'(i); step(); end
        data_in0 = 6'h0A; step();
        chk("t3_error", error_out, 1);
        clr_in(); pop = 1; step();
        chk("t3_pop_ignored", valid_out, 0);
        do_reset();
        chk("t3_err_cleared", error_out, 0);

        // push to a full D0 together with a pop of D0 is legal
        bring_up(2'd1);
        push0 = 1;
        for (int i = 1; i <= 4; i++) begin data_in0 = 6'(i); step(); end
        data_in0 = 6'h08; pop = 1; step();
        chk("t4_no_error", error_out, 0);
        chk("t4_oldest", data_out, 6'h01);
        chk("t4_still_full", pausa0, 1);
        drain();

        // 33+ deliveries from D1 saturate count1, then interleave both
        do_reset();
        bring_up(2'd1);
        for (int i = 0; i < 36; i++) begin
            push1 = 1; data_in1 = {2'b01, 4'(i)}; pop = 1; step();
        end
        clr_in(); pop = 1; step(); step();
        chk("t5_count1_sat", count1, 31);
        clr_in();
        for (int i = 0; i < 4; i++) begin
            push0 = 1; data_in0 = {2'b00, 4'(i)};
            push1 = 1; data_in1 = {2'b01, 4'(i + 8)};
            step();
        end
        drain();

        // D0 word carrying destination 1
        do_reset();
        bring_up(2'd1);
        push0 = 1; data_in0 = 6'h10; step();
        clr_in(); pop = 1; step();
`ifdef RX_DEST_CHECK_EN
        chk("t6_dest_err", dest_err, 1);
        chk("t6_state_kept", idle_out, 1);
        chk("t6_dropped", valid_out, 0);
`else
        chk("t6_passed", data_out, 6'h10);
        chk("t6_passed_v", valid_out, 1);
        chk("t6_no_dest_err", dest_err, 0);
`endif

        // randomized traffic, with occasional init and mid-operation resets
        for (int r = 0; r < 6; r++) begin
            do_reset();
            bring_up(2'($urandom_range(1, 3)));
            for (int c = 0; c < 300; c++) begin
                push0 = ($urandom_range(0, 99) < 45);
                push1 = ($urandom_range(0, 99) < 45);
                data_in0 = rnd_word(1'b0);
                data_in1 = rnd_word(1'b1);
                pop = ($urandom_range(0, 99) < 55 + r * 5);
                init = ($urandom_range(0, 99) < 2);
                umbral_in = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 199) == 0) begin
                    do_reset();
                    bring_up(2'($urandom_range(1, 3)));
                end else begin
                    step();
                end
            end
            clr_in();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
